mem_reader: RTL and testbench
=============================

MEM_READER -- requirements
Module: mem_reader

Interface
REQ-001 SHALL have parameter DW, default 32, word width read from MEM.
REQ-002 SHALL have parameter AW, default 5, MEM address width (2^AW words).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  burst request, sampled only in IDLE.
REQ-006 SHALL have port base  input  AW  first address of the burst, sampled with start.
REQ-007 SHALL have port count  input  AW+1  words to read, sampled with start.
REQ-008 SHALL have port abort  input  1  synchronous burst cancel.
REQ-009 SHALL have port Dir  output  AW  address driven to MEM.
REQ-010 SHALL have port Ewr  output  1  MEM write enable, constant 0.
REQ-011 SHALL have port Mdata  input  DW  MEM read data (MEM Dout), combinational from Dir.
REQ-012 SHALL have port Dout  output  DW  streamed word.
REQ-013 SHALL have port Dout_valid  output  1  Dout holds an unconsumed word.
REQ-014 SHALL have port Dout_ready  input  1  consumer accepts Dout.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse at burst end.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, HOLD, DONE.
REQ-018 SHALL, in IDLE with start=1, latch base into addr and count into remaining, then go to FETCH; count=0 goes straight to DONE.
REQ-019 SHALL clamp count values above 2^AW to 2^AW.
REQ-020 SHALL drive Dir=addr in FETCH and hold Dir at its last value in all other states.
REQ-021 SHALL, in FETCH, register Mdata into Dout, set Dout_valid, and go to HOLD (first word valid two edges after start).
REQ-022 SHALL, in HOLD, keep Dout and Dout_valid stable while Dout_ready=0.
REQ-023 SHALL, in HOLD, on Dout_valid&&Dout_ready clear Dout_valid and decrement remaining; remaining becomes 0 -> DONE, else addr+1 -> FETCH.
REQ-024 SHALL wrap addr from 2^AW-1 to 0.
REQ-025 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-026 SHALL ignore start whenever busy=1.
REQ-027 SHALL, on abort=1 in any non-IDLE state, go to IDLE at the next edge with Dout_valid=0 and no done pulse; abort takes priority over handshake completion in the same cycle.
REQ-028 SHALL hold Ewr=0 at all times, including during reset.
REQ-029 SHALL sustain one word per two cycles with Dout_ready held high.

Reset
REQ-030 SHALL, while rst_n=0, immediately force state IDLE and Dir=0, Dout=0, Dout_valid=0, busy=0, done=0, addr=0, remaining=0, independent of clk.
REQ-031 SHALL, on reset mid-burst, discard the burst; the first edge after release sees IDLE and requires a fresh start.

Verification
REQ-032 SHALL cover: MEM preloaded [1]=13,[2]=11,[3]=12; base=1, count=3, Dout_ready=1 -> Dout 13,11,12 on cycles 2,4,6 after start, done pulse once, busy then 0.
REQ-033 SHALL cover: base=2, count=2, Dout_ready low 3 cycles after first valid -> Dout=11 held stable with Dout_valid=1, then 11,12 delivered, no word lost or repeated.
REQ-034 SHALL cover: MEM [31]=5,[0]=9,[1]=13; base=31, count=3 -> Dir sequence 31,0,1, Dout 5,9,13.
REQ-035 SHALL cover: start with count=0 -> done one cycle later, Dout_valid never set; count=40 -> exactly 32 words delivered.
REQ-036 SHALL cover: abort during second HOLD of count=5 burst -> IDLE next edge, Dout_valid=0, no done; a following start with base=6, count=2 -> 120,56.
REQ-037 SHALL cover: rst_n low mid-burst between clock edges -> all outputs 0 without a clock edge, Ewr=0 throughout.

Source files
------------

// File: rtl/mem_reader.sv
// Burst reader: fetches `count` consecutive words from a combinational-read
// memory starting at `base` and streams them out over a valid/ready port.
module mem_reader #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   count,
  input  logic          abort,
  output logic [AW-1:0] Dir,
  output logic          Ewr,
  input  logic [DW-1:0] Mdata,
  output logic [DW-1:0] Dout,
  output logic          Dout_valid,
  input  logic          Dout_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

  localparam logic [AW:0] MAX_CNT = {1'b1, {AW{1'b0}}};

  state_t        state;
  logic [AW-1:0] addr;
  logic [AW:0]   remaining;

  assign Ewr = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      Dir        <= '0;
      Dout       <= '0;
      Dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (abort && state != IDLE) begin
      state      <= IDLE;
      Dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            addr <= base;
            if (count == '0) begin
              remaining <= '0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              remaining <= (count > MAX_CNT) ? MAX_CNT : count;
              // Dir is loaded on entry so it already equals addr throughout FETCH.
              Dir       <= base;
              state     <= FETCH;
            end
          end
        end
        FETCH: begin
          Dout       <= Mdata;
          Dout_valid <= 1'b1;
          state      <= HOLD;
        end
        HOLD: begin
          if (Dout_valid && Dout_ready) begin
            Dout_valid <= 1'b0;
            remaining  <= remaining - 1'b1;
            if (remaining == {{AW{1'b0}}, 1'b1}) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              addr  <= addr + 1'b1;
              Dir   <= addr + 1'b1;
              state <= FETCH;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_reader.sv
// Scoreboard bench for mem_reader: expected (address, word) pairs are queued
// when a burst is requested and matched against every accepted output word.
module tb_mem_reader;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   count;
  logic          abort;
  logic [AW-1:0] Dir;
  logic          Ewr;
  logic [DW-1:0] Mdata;
  logic [DW-1:0] Dout;
  logic          Dout_valid;
  logic          Dout_ready;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [32];
  exp_t          sb [$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_done   = 0;
  int            d0;

  mem_reader #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .count(count),
    .abort(abort), .Dir(Dir), .Ewr(Ewr), .Mdata(Mdata), .Dout(Dout),
    .Dout_valid(Dout_valid), .Dout_ready(Dout_ready), .busy(busy), .done(done)
  );

  assign Mdata = mem[Dir];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Called just after a rising edge; returns just after the edge that samples start.
  task automatic run_start(input logic [AW-1:0] b, input logic [AW:0] c);
    int unsigned n;
    logic [AW-1:0] a;
    exp_t e;
    n = (c > 32) ? 32 : int'(c);
    a = b;
    for (int unsigned i = 0; i < n; i++) begin
      e.a = a;
      e.d = mem[a];
      sb.push_back(e);
      a = a + 1'b1;
    end
    start = 1'b1;
    base  = b;
    count = c;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int unsigned i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(tag, busy, 0);
    check({tag, "_drain"}, sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done) n_done++;
      if (Dout_valid && Dout_ready && !abort) begin
        if (sb.size() == 0) check("unexpected_word", Dout_valid, 0);
        else begin
          e = sb.pop_front();
          check("dout", Dout, e.d);
          check("dir", Dir, e.a);
          check("ewr", Ewr, 0);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'(i * 37 + 1000);
    mem[1] = 13; mem[2] = 11; mem[3] = 12;
    mem[31] = 5; mem[0] = 9;
    mem[6] = 120; mem[7] = 56;
    rst_n = 1'b1; start = 1'b0; base = '0; count = '0; abort = 1'b0; Dout_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_dout_valid", Dout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dir", Dir, 0);
    check("rst_dout", Dout, 0);
    check("rst_ewr", Ewr, 0);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic burst: valid on cycles 2,4,6, then one done pulse.
    d0 = n_done;
    run_start(1, 3);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t1_valid", Dout_valid, (k % 2));
      check("t1_busy", busy, 1);
    end
    @(negedge clk);
    check("t1_done", done, 1);
    @(negedge clk);
    check("t1_done_end", done, 0);
    check("t1_busy_end", busy, 0);
    check("t1_done_cnt", n_done - d0, 1);
    @(posedge clk); #1;

    // Consumer stall keeps the first word stable.
    Dout_ready = 1'b0;
    run_start(2, 2);
    @(negedge clk);
    check("t2_valid0", Dout_valid, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t2_hold_valid", Dout_valid, 1);
      check("t2_hold_dout", Dout, 11);
    end
    @(posedge clk);
    #1 Dout_ready = 1'b1;
    wait_idle("t2_idle");

    // Address wrap; start held high mid-burst must be ignored.
    run_start(31, 3);
    start = 1'b1; base = 0; count = 3;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1 start = 1'b0;
    wait_idle("t3_idle");

    // Zero count: done one cycle later, no data.
    d0 = n_done;
    run_start(9, 0);
    @(negedge clk);
    check("t4_done", done, 1);
    check("t4_valid", Dout_valid, 0);
    @(negedge clk);
    check("t4_done_end", done, 0);
    check("t4_valid_end", Dout_valid, 0);
    check("t4_busy_end", busy, 0);
    @(posedge clk); #1;

    // Oversized count clamps to 32 words.
    d0 = n_done;
    run_start(5, 40);
    wait_idle("t5_idle");
    check("t5_done_cnt", n_done - d0, 1);

    // Abort during the second HOLD.
    d0 = n_done;
    run_start(10, 5);
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("t6_busy", busy, 0);
    check("t6_valid", Dout_valid, 0);
    check("t6_done", done, 0);
    check("t6_sb_left", sb.size(), 4);
    sb.delete();
    @(negedge clk);
    check("t6_no_done", n_done - d0, 0);
    check("t6_idle_busy", busy, 0);
    @(posedge clk); #1;
    run_start(6, 2);
    wait_idle("t6_restart");

    // Asynchronous reset between edges mid-burst.
    run_start(1, 3);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t7_dir", Dir, 0);
    check("t7_dout", Dout, 0);
    check("t7_valid", Dout_valid, 0);
    check("t7_busy", busy, 0);
    check("t7_done", done, 0);
    check("t7_ewr", Ewr, 0);
    sb.delete();
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t7_post_busy", busy, 0);
    check("t7_post_valid", Dout_valid, 0);
    @(posedge clk); #1;
    run_start(1, 3);
    wait_idle("t7_restart");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
